// File: rtl/fp_addsub_pipe.sv
// fp_addsub_pipe: two-stage signed fixed-point add/subtract with
// Q-format alignment, rounding, saturate/wrap and valid/ready flow.
module fp_addsub_pipe #(
  parameter int WI1   = 4,
  parameter int WF1   = 4,
  parameter int WI2   = 4,
  parameter int WF2   = 4,
  parameter int WIO   = ((WI1 > WI2) ? WI1 : WI2) + 1,
  parameter int WFO   = (WF1 > WF2) ? WF1 : WF2,
  parameter bit SAT   = 1'b1,
  parameter bit ROUND = 1'b0
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [WI1+WF1-1:0] in1,
  input  logic signed [WI2+WF2-1:0] in2,
  input  logic                      SUB,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [WIO+WFO-1:0] out,
  output logic                      OVF,
  output logic                      OVF_STICKY,
  input  logic                      OVF_CLR
);

  localparam int WIP = ((WI1 > WI2) ? WI1 : WI2) + 1;
  localparam int WFP = (WF1 > WF2) ? WF1 : WF2;
  localparam int WP  = WIP + WFP;
  localparam int WO  = WIO + WFO;
  localparam int WR  = WIP + 1 + WFO;
  localparam int WW  = (WR > WO) ? WR : WO;
  localparam int UP  = (WFO > WFP) ? WFO - WFP : 0;
  localparam int DN  = (WFP > WFO) ? WFP - WFO : 0;
  localparam int WT  = WIP + 1 + WFP + UP;
  localparam int RSH = (DN > 0) ? DN - 1 : 0;

  localparam logic [WT-1:0] RINC =
    (ROUND && (DN > 0)) ? (WT'(1) << RSH) : '0;

  logic          s2_adv;
  logic          xfer_in;
  logic          xfer_out;

  logic          s1_valid_d, s1_valid_q;
  logic [WP-1:0] s1_sum_d, s1_sum_q;
  logic          s2_valid_d, s2_valid_q;
  logic [WO-1:0] out_d, out_q;
  logic          ovf_d, ovf_q;
  logic          sticky_d, sticky_q;

  logic signed [WP-1:0] a_ext;
  logic signed [WP-1:0] b_ext;
  logic signed [WP-1:0] sum;

  logic signed [WT-1:0] t_val;
  logic signed [WR-1:0] r_val;
  logic signed [WW-1:0] r_wide;
  logic [WW-WO:0]       r_top;
  logic                 fits;
  logic                 r_sign;
  logic [WO-1:0]        maxp;
  logic [WO-1:0]        res;

  // Handshake: stage 2 frees when empty or drained; stage 1 then
  assign s2_adv    = !s2_valid_q || out_ready;
  assign in_ready  = !s1_valid_q || s2_adv;
  assign xfer_in   = in_valid && in_ready;
  assign xfer_out  = s2_valid_q && out_ready;

  assign out_valid  = s2_valid_q;
  assign out        = out_q;
  assign OVF        = ovf_q;
  assign OVF_STICKY = sticky_q;

  // Align both operands to the internal Q format and add/sub exactly
  always_comb begin
    a_ext = WP'(in1) <<< (WFP - WF1);
    b_ext = WP'(in2) <<< (WFP - WF2);
    sum   = SUB ? (a_ext - b_ext) : (a_ext + b_ext);
  end

  // Resize fraction (pad or round/floor) keeping one spare int bit
  always_comb begin
    t_val = (WT'($signed(s1_sum_q)) <<< UP) + $signed(RINC);
    r_val = WR'(t_val >>> DN);
  end

  // Integer range check and saturate or wrap into the output width
  always_comb begin
    r_wide = WW'(r_val);
    r_top  = r_wide[WW-1:WO-1];
    fits   = (&r_top) || !(|r_top);
    r_sign = r_wide[WW-1];
    maxp   = '1;
    maxp[WO-1] = 1'b0;
    res    = r_wide[WO-1:0];
    if (!fits && SAT) begin
      res = r_sign ? ~maxp : maxp;
    end
  end

  // Next-state for both pipeline stages and the sticky flag
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sum_d   = s1_sum_q;
    s2_valid_d = s2_valid_q;
    out_d      = out_q;
    ovf_d      = ovf_q;
    sticky_d   = sticky_q;
    if (in_ready) begin
      s1_valid_d = in_valid;
    end
    if (xfer_in) begin
      s1_sum_d = sum;
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_d = res;
        ovf_d = !fits;
      end
    end
    if (xfer_out && ovf_q) begin
      sticky_d = 1'b1;
    end else if (OVF_CLR) begin
      sticky_d = 1'b0;
    end
  end

  // Pipeline and flag registers, cleared asynchronously
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1_valid_q <= 1'b0;
      s1_sum_q   <= '0;
      s2_valid_q <= 1'b0;
      out_q      <= '0;
      ovf_q      <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_sum_q   <= s1_sum_d;
      s2_valid_q <= s2_valid_d;
      out_q      <= out_d;
      ovf_q      <= ovf_d;
      sticky_q   <= sticky_d;
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// tb_fp_addsub_pipe: five configurations driven in lockstep,
// expected results queued at acceptance and popped by a monitor.
module tb_fp_addsub_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       in_valid  = 1'b0;
  logic       out_ready = 1'b1;
  logic       sub       = 1'b0;
  logic       ovf_clr   = 1'b0;
  logic [7:0] in1       = '0;
  logic [7:0] in2       = '0;

  logic       rdy_d, rdy_s, rdy_w, rdy_r1, rdy_r0;
  logic       vld_d, vld_s, vld_w, vld_r1, vld_r0;
  logic       ovf_d, ovf_s, ovf_w, ovf_r1, ovf_r0;
  logic       stk_d, stk_s, stk_w, stk_r1, stk_r0;
  logic [8:0] out_d;
  logic [7:0] out_s, out_w;
  logic [6:0] out_r1, out_r0;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [8:0] d;
    logic [7:0] s;
    logic [7:0] w;
    logic [6:0] r1;
    logic [6:0] r0;
    logic [4:0] ovf;
  } vec_t;

  vec_t tbl [9];
  vec_t sb [$];
  int   errs     = 0;
  int   checks   = 0;
  int   accepted = 0;

  fp_addsub_pipe u_d (
    .CLK(clk), .RESET(rst),
    .in_valid(in_valid), .in_ready(rdy_d),
    .in1(in1), .in2(in2), .SUB(sub),
    .out_valid(vld_d), .out_ready(out_ready),
    .out(out_d), .OVF(ovf_d),
    .OVF_STICKY(stk_d), .OVF_CLR(ovf_clr)
  );

  fp_addsub_pipe #(.WIO(4), .WFO(4), .SAT(1'b1)) u_s (
    .CLK(clk), .RESET(rst),
    .in_valid(in_valid), .in_ready(rdy_s),
    .in1(in1), .in2(in2), .SUB(sub),
    .out_valid(vld_s), .out_ready(out_ready),
    .out(out_s), .OVF(ovf_s),
    .OVF_STICKY(stk_s), .OVF_CLR(ovf_clr)
  );

  fp_addsub_pipe #(.WIO(4), .WFO(4), .SAT(1'b0)) u_w (
    .CLK(clk), .RESET(rst),
    .in_valid(in_valid), .in_ready(rdy_w),
    .in1(in1), .in2(in2), .SUB(sub),
    .out_valid(vld_w), .out_ready(out_ready),
    .out(out_w), .OVF(ovf_w),
    .OVF_STICKY(stk_w), .OVF_CLR(ovf_clr)
  );

  fp_addsub_pipe #(.WFO(2), .ROUND(1'b1)) u_r1 (
    .CLK(clk), .RESET(rst),
    .in_valid(in_valid), .in_ready(rdy_r1),
    .in1(in1), .in2(in2), .SUB(sub),
    .out_valid(vld_r1), .out_ready(out_ready),
    .out(out_r1), .OVF(ovf_r1),
    .OVF_STICKY(stk_r1), .OVF_CLR(ovf_clr)
  );

  fp_addsub_pipe #(.WFO(2), .ROUND(1'b0)) u_r0 (
    .CLK(clk), .RESET(rst),
    .in_valid(in_valid), .in_ready(rdy_r0),
    .in1(in1), .in2(in2), .SUB(sub),
    .out_valid(vld_r0), .out_ready(out_ready),
    .out(out_r0), .OVF(ovf_r0),
    .OVF_STICKY(stk_r0), .OVF_CLR(ovf_clr)
  );

  function automatic void chk(string name,
                              logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: pop and compare on every output transfer
  always @(negedge clk) begin
    if (!rst && (vld_d || vld_s || vld_w || vld_r1 || vld_r0)) begin
      chk("valid_align", {vld_s, vld_w, vld_r1, vld_r0},
          {4{vld_d}});
    end
    if (!rst && vld_d && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 32'd1, 32'd0);
      end else begin
        vec_t e;
        e = sb.pop_front();
        chk("out_d",  32'(out_d),  32'(e.d));
        chk("out_s",  32'(out_s),  32'(e.s));
        chk("out_w",  32'(out_w),  32'(e.w));
        chk("out_r1", 32'(out_r1), 32'(e.r1));
        chk("out_r0", 32'(out_r0), 32'(e.r0));
        chk("ovf_vec",
            32'({ovf_d, ovf_s, ovf_w, ovf_r1, ovf_r0}),
            32'(e.ovf));
      end
    end
  end

  task automatic send(input vec_t v);
    bit done;
    done     = 1'b0;
    in1      = v.a;
    in2      = v.b;
    sub      = v.sub;
    in_valid = 1'b1;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (rdy_d) begin
        sb.push_back(v);
        accepted++;
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit empty;
    empty = 1'b0;
    for (int c = 0; c < 100 && !empty; c++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) empty = 1'b1;
    end
    if (!empty) chk("drain_timeout", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic clr_pulse();
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
  endtask

  initial begin
    //               a      b    sub  d       s      w      r1     r0     ovf
    tbl[0] = '{8'h7F, 8'h01, 1'b0, 9'h080, 8'h7F, 8'h80, 7'h20, 7'h20, 5'b01100};
    tbl[1] = '{8'h10, 8'h30, 1'b1, 9'h1E0, 8'hE0, 8'hE0, 7'h78, 7'h78, 5'b00000};
    tbl[2] = '{8'h00, 8'h80, 1'b1, 9'h080, 8'h7F, 8'h80, 7'h20, 7'h20, 5'b01100};
    tbl[3] = '{8'h03, 8'h00, 1'b0, 9'h003, 8'h03, 8'h03, 7'h01, 7'h00, 5'b00000};
    tbl[4] = '{8'hFD, 8'h00, 1'b0, 9'h1FD, 8'hFD, 8'hFD, 7'h7F, 7'h7F, 5'b00000};
    tbl[5] = '{8'h80, 8'h80, 1'b0, 9'h100, 8'h80, 8'h00, 7'h40, 7'h40, 5'b01100};
    tbl[6] = '{8'h7F, 8'h80, 1'b1, 9'h0FF, 8'h7F, 8'hFF, 7'h3F, 7'h3F, 5'b01110};
    tbl[7] = '{8'h08, 8'h02, 1'b0, 9'h00A, 8'h0A, 8'h0A, 7'h03, 7'h02, 5'b00000};
    tbl[8] = '{8'h01, 8'h01, 1'b0, 9'h002, 8'h02, 8'h02, 7'h01, 7'h00, 5'b00000};

    // reset state
    @(negedge clk);
    chk("rst_valid", 32'(vld_d), 32'd0);
    chk("rst_out", 32'(out_d), 32'd0);
    chk("rst_ovf", 32'(ovf_d), 32'd0);
    chk("rst_sticky", 32'(stk_s), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(rdy_d), 32'd1);
    chk("post_rst_valid", 32'(vld_d), 32'd0);
    @(posedge clk);
    #1;

    // no overflow leaves sticky clear
    send(tbl[1]);
    drain();
    @(negedge clk);
    chk("sticky_quiet", 32'(stk_s), 32'd0);

    // overflow sets sticky only where it overflowed
    @(posedge clk);
    #1;
    send(tbl[0]);
    drain();
    @(negedge clk);
    chk("sticky_set_s", 32'(stk_s), 32'd1);
    chk("sticky_set_w", 32'(stk_w), 32'd1);
    chk("sticky_none_d", 32'(stk_d), 32'd0);
    @(posedge clk);
    #1;
    clr_pulse();
    @(negedge clk);
    chk("sticky_clr", 32'(stk_s), 32'd0);
    @(posedge clk);
    #1;

    // back-to-back directed vectors
    for (int i = 2; i < 9; i++) send(tbl[i]);
    drain();

    // clear coinciding with a new overflow: set wins
    clr_pulse();
    @(negedge clk);
    chk("sticky_clr2", 32'(stk_s), 32'd0);
    @(posedge clk);
    #1;
    send(tbl[0]);
    @(posedge clk);
    #1;
    ovf_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_clr = 1'b0;
    @(negedge clk);
    chk("sticky_set_wins", 32'(stk_s), 32'd1);
    @(posedge clk);
    #1;
    drain();

    // backpressure: only two accepted while stalled
    out_ready = 1'b0;
    accepted  = 0;
    fork
      begin
        for (int i = 4; i < 9; i++) send(tbl[i]);
      end
      begin
        repeat (4) @(negedge clk);
        #2;
        chk("bp_accepted", 32'(accepted), 32'd2);
        chk("bp_in_ready", 32'(rdy_d), 32'd0);
        chk("bp_hold_out", 32'(out_d), 32'(tbl[4].d));
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_total", 32'(accepted), 32'd5);

    // reset with two transactions in flight
    out_ready = 1'b0;
    send(tbl[0]);
    send(tbl[1]);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(vld_d), 32'd0);
    chk("mid_rst_sticky", 32'(stk_s), 32'd0);
    chk("mid_rst_ovf", 32'(ovf_s), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rel_valid", 32'(vld_d), 32'd0);
    chk("rel_in_ready", 32'(rdy_d), 32'd1);
    @(posedge clk);
    #1;

    // single input emerges after exactly two edges
    send(tbl[3]);
    @(negedge clk);
    chk("lat_early", 32'(vld_d), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_on_time", 32'(vld_d), 32'd1);
    @(posedge clk);
    #1;
    drain();

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
